// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Direct-mapped branch target buffer with 2-bit saturating
//               counters, sitting beside the IF stage.
//               Lookup (combinational, 0-cycle):
//                 if_pc        -> branch_taken, pred_target
//               Update (rising clk, from ID, conditional branches only):
//                 upd_valid, upd_pc, upd_taken, upd_target
//                 -> upd_mispred (registered, one cycle after the update)
//               clk  : rising-edge clock
//               arst : asynchronous active-high reset
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
    parameter int PC_W  = 64,
    parameter int IDX_W = 4
) (
    input  logic            clk,
    input  logic            arst,
    input  logic [PC_W-1:0] if_pc,
    output logic            branch_taken,
    output logic [PC_W-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    output logic            upd_mispred
);

    localparam int c_DEPTH = 2 ** IDX_W;
    localparam int c_TAG_W = PC_W - IDX_W - 2;

    // Counter encodings
    localparam logic [1:0] c_CTR_SNT = 2'b00;
    localparam logic [1:0] c_CTR_WNT = 2'b01;
    localparam logic [1:0] c_CTR_WT  = 2'b10;
    localparam logic [1:0] c_CTR_ST  = 2'b11;

    // Table storage
    logic               r_valid  [c_DEPTH];
    logic [c_TAG_W-1:0] r_tag    [c_DEPTH];
    logic [PC_W-1:0]    r_target [c_DEPTH];
    logic [1:0]         r_ctr    [c_DEPTH];
    logic               r_mispred;

    // Field extraction; pc[1:0] carries no information for aligned branches
    logic [IDX_W-1:0]   w_lk_idx;
    logic [c_TAG_W-1:0] w_lk_tag;
    logic [IDX_W-1:0]   w_up_idx;
    logic [c_TAG_W-1:0] w_up_tag;
    logic               w_unused_low_bits;

    assign w_lk_idx = if_pc[IDX_W+1:2];
    assign w_lk_tag = if_pc[PC_W-1:IDX_W+2];
    assign w_up_idx = upd_pc[IDX_W+1:2];
    assign w_up_tag = upd_pc[PC_W-1:IDX_W+2];
    assign w_unused_low_bits = ^{if_pc[1:0], upd_pc[1:0]};

    // ------------------------------------------------------------------
    // Lookup: reads the registered table, so a same-cycle update to the
    // same entry is only seen from the following cycle.
    // ------------------------------------------------------------------
    logic w_lk_hit;
    logic w_lk_taken;

    assign w_lk_hit     = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign w_lk_taken   = w_lk_hit && r_ctr[w_lk_idx][1];
    assign branch_taken = w_lk_taken;
    assign pred_target  = w_lk_taken ? r_target[w_lk_idx] : '0;

    // ------------------------------------------------------------------
    // Update side: prediction the table held for upd_pc before the write.
    // A miss counts as predicted not-taken.
    // ------------------------------------------------------------------
    logic w_up_hit;
    logic w_up_pred;

    assign w_up_hit  = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    assign w_up_pred = w_up_hit && r_ctr[w_up_idx][1];

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= c_CTR_WNT;
            end
            r_mispred <= 1'b0;
        end else begin
            r_mispred <= upd_valid && (upd_taken != w_up_pred);
            if (upd_valid) begin
                if (w_up_hit) begin
                    if (upd_taken) begin
                        if (r_ctr[w_up_idx] != c_CTR_ST)
                            r_ctr[w_up_idx] <= r_ctr[w_up_idx] + 2'b01;
                        r_target[w_up_idx] <= upd_target;
                    end else if (r_ctr[w_up_idx] != c_CTR_SNT) begin
                        r_ctr[w_up_idx] <= r_ctr[w_up_idx] - 2'b01;
                    end
                end else begin
                    // Allocate or evict the aliasing occupant
                    r_valid[w_up_idx]  <= 1'b1;
                    r_tag[w_up_idx]    <= w_up_tag;
                    r_target[w_up_idx] <= upd_target;
                    r_ctr[w_up_idx]    <= upd_taken ? c_CTR_WT : c_CTR_WNT;
                end
            end
        end
    end

    assign upd_mispred = r_mispred;

endmodule
`default_nettype wire
